// File: rtl/tpu_float_pkg.sv
// Shared definitions for the TPU sign/exponent/mantissa float datapath:
// default field widths, zero detection and field-position helpers.
package tpu_float_pkg;

    localparam int EXP_W_DEF = 4;
    localparam int MAN_W_DEF = 3;
    localparam int BIAS_DEF  = 7;
    localparam int TAG_W_DEF = 4;

    // Largest biased exponent representable in an exp_w-bit field.
    function automatic int fp_max_exp(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Bit position of the sign in a {sign, exp, man} word.
    function automatic int fp_sign_pos(input int exp_w, input int man_w);
        return exp_w + man_w;
    endfunction

    // The caller passes the zero-extended {exp, man} fields; the sign never matters.
    function automatic logic fp_is_zero(input logic [31:0] exp_man);
        return (exp_man == 32'd0);
    endfunction

endpackage

// File: rtl/float_norm_round.sv
// Normalises the raw mantissa product and, when FLOAT_MULT_RNE_EN is defined,
// rounds it to nearest-even using the discarded remainder bits.
module float_norm_round
    import tpu_float_pkg::*;
#(
    parameter int MAN_W = MAN_W_DEF,
    parameter int XW    = EXP_W_DEF + 2
) (
    input  logic [2*MAN_W+1:0]    prod,
    input  logic signed [XW-1:0]  exp_in,
    output logic [MAN_W-1:0]      man,
    output logic signed [XW-1:0]  exp_out
);

    logic                  msb;
    logic [MAN_W-1:0]      man_t;
    logic signed [XW-1:0]  exp_t;

    assign msb   = prod[2*MAN_W+1];
    assign man_t = msb ? prod[2*MAN_W:MAN_W+1] : prod[2*MAN_W-1:MAN_W];
    assign exp_t = exp_in + XW'(msb);

`ifdef FLOAT_MULT_RNE_EN
    localparam logic [MAN_W:0] HALF = {1'b1, {MAN_W{1'b0}}};

    logic [MAN_W:0] rem;
    logic           up;
    logic [MAN_W:0] man_r;

    // Remainder is aligned to MAN_W+1 bits so both normalise cases share one compare.
    assign rem     = msb ? prod[MAN_W:0] : {prod[MAN_W-1:0], 1'b0};
    assign up      = (rem > HALF) | ((rem == HALF) & man_t[0]);
    assign man_r   = {1'b0, man_t} + (MAN_W+1)'(up);
    assign man     = man_r[MAN_W-1:0];
    assign exp_out = exp_t + XW'(man_r[MAN_W]);
`else
    logic unused_rem;

    assign unused_rem = ^prod[MAN_W-1:0];
    assign man        = man_t;
    assign exp_out    = exp_t;
`endif

endmodule

// File: rtl/float_mult_pipe.sv
// Three-stage pipelined float multiplier with valid/ready handshake, sideband tag,
// overflow/underflow classification; FLOAT_MULT_RNE_EN enables nearest-even rounding.
module float_mult_pipe
    import tpu_float_pkg::*;
#(
    parameter int EXP_W    = EXP_W_DEF,
    parameter int MAN_W    = MAN_W_DEF,
    parameter int BIAS     = BIAS_DEF,
    parameter int SATURATE = 0,
    parameter int TAG_W    = TAG_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_p,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_ovf,
    output logic                     out_unf
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int SP   = fp_sign_pos(EXP_W, MAN_W);
    localparam int PW   = 2*MAN_W + 2;
    localparam int XW   = EXP_W + 2;
    localparam logic signed [XW-1:0] EXP_MAX = XW'(fp_max_exp(EXP_W));

    logic stall;
    logic accept;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    // Stage 1: sign, zero detect, exponent sum, mantissa product
    logic                  s1_zero_c;
    logic [XW-1:0]         s1_exp_c;
    logic [PW-1:0]         s1_prod_c;

    assign s1_zero_c = fp_is_zero(32'(in_a[W-2:0])) | fp_is_zero(32'(in_b[W-2:0]));
    assign s1_exp_c  = XW'(in_a[W-2:MAN_W]) + XW'(in_b[W-2:MAN_W]) - XW'(BIAS);
    assign s1_prod_c = PW'({1'b1, in_a[MAN_W-1:0]}) * PW'({1'b1, in_b[MAN_W-1:0]});

    logic                  s1_valid, s1_sign, s1_zero;
    logic signed [XW-1:0]  s1_exp;
    logic [PW-1:0]         s1_prod;
    logic [TAG_W-1:0]      s1_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_sign <= in_a[SP] ^ in_b[SP];
                s1_zero <= s1_zero_c;
                s1_exp  <= s1_exp_c;
                s1_prod <= s1_prod_c;
                s1_tag  <= in_tag;
            end
        end
    end

    // Stage 2: normalise (and optionally round)
    logic [MAN_W-1:0]      n_man;
    logic signed [XW-1:0]  n_exp;

    float_norm_round #(.MAN_W(MAN_W), .XW(XW)) u_norm (
        .prod    (s1_prod),
        .exp_in  (s1_exp),
        .man     (n_man),
        .exp_out (n_exp)
    );

    logic                  s2_valid, s2_sign, s2_zero;
    logic signed [XW-1:0]  s2_exp;
    logic [MAN_W-1:0]      s2_man;
    logic [TAG_W-1:0]      s2_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign <= s1_sign;
                s2_zero <= s1_zero;
                s2_exp  <= n_exp;
                s2_man  <= n_man;
                s2_tag  <= s1_tag;
            end
        end
    end

    // Stage 3: classify and pack; zero results are always +0
    logic [W-1:0] p_c;
    logic         ovf_c, unf_c;

    always_comb begin
        p_c   = '0;
        ovf_c = 1'b0;
        unf_c = 1'b0;
        if (s2_zero) begin
            p_c = '0;
        end else if (s2_exp[XW-1]) begin
            unf_c = 1'b1;
        end else if (s2_exp > EXP_MAX) begin
            ovf_c = 1'b1;
            if (SATURATE != 0)
                p_c = {s2_sign, {(W-1){1'b1}}};
        end else begin
            p_c = {s2_sign & (|{s2_exp[EXP_W-1:0], s2_man}), s2_exp[EXP_W-1:0], s2_man};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_p     <= '0;
            out_tag   <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
        end else if (!stall) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_p   <= p_c;
                out_tag <= s2_tag;
                out_ovf <= ovf_c;
                out_unf <= unf_c;
            end
        end
    end

endmodule

// File: tb/tb_float_mult_pipe.sv
// Directed bench for float_mult_pipe: a default instance and a SATURATE=1 instance
// driven in lockstep, with hand-computed products, a stalled stream and a mid-flight reset.
module tb_float_mult_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_a, in_b;
    logic [3:0] in_tag;
    logic       out_ready;

    logic       in_ready, out_valid, out_ovf, out_unf;
    logic [7:0] out_p;
    logic [3:0] out_tag;

    logic       sat_in_ready, sat_out_valid, sat_ovf, sat_unf;
    logic [7:0] sat_p;
    logic [3:0] sat_tag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    float_mult_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .out_tag(out_tag), .out_ovf(out_ovf), .out_unf(out_unf)
    );

    float_mult_pipe #(.SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_p(sat_p),
        .out_tag(sat_tag), .out_ovf(sat_ovf), .out_unf(sat_unf)
    );

    task automatic chk(input string nm, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", nm, what, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation: checks latency, product, flags, tag and the saturating twin.
    task automatic run_one(input string nm, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] t, input logic [7:0] ep, input logic eo,
                           input logic eu, input logic [7:0] ep_sat);
        int k;
        in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
        chk(nm, "in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 6) begin
            step();
            k++;
        end
        chk(nm, "latency", 32'(k), 32'd2);
        chk(nm, "p", 32'(out_p), 32'(ep));
        chk(nm, "tag", 32'(out_tag), 32'(t));
        chk(nm, "ovf", 32'(out_ovf), 32'(eo));
        chk(nm, "unf", 32'(out_unf), 32'(eu));
        chk(nm, "sat_valid", 32'(sat_out_valid), 32'd1);
        chk(nm, "sat_p", 32'(sat_p), 32'(ep_sat));
        chk(nm, "sat_ovf", 32'(sat_ovf), 32'(eo));
        chk(nm, "sat_unf", 32'(sat_unf), 32'(eu));
        chk(nm, "sat_tag", 32'(sat_tag), 32'(t));
        step();
        chk(nm, "bubble", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sa [8];
        logic [7:0] sb [8];
        logic [7:0] sp [8];
        int snd, rcv, stalls;

        sa = '{8'h3C, 8'h40, 8'h44, 8'h3C, 8'hC0, 8'h30, 8'h3A, 8'h55};
        sb = '{8'h3C, 8'h40, 8'h40, 8'h44, 8'h3C, 8'h30, 8'h3A, 8'h38};
        sp = '{8'h41, 8'h48, 8'h4C, 8'h49, 8'hC4, 8'h28, 8'h3C, 8'h55};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
        step();
        step();
        chk("reset", "out_valid", 32'(out_valid), 32'd0);
        chk("reset", "out_p", 32'(out_p), 32'd0);
        chk("reset", "out_tag", 32'(out_tag), 32'd0);
        chk("reset", "flags", 32'({out_ovf, out_unf}), 32'd0);
        rst = 1'b0;
        chk("reset", "in_ready", 32'(in_ready), 32'd1);

        run_one("mul15",  8'h3C, 8'h3C, 4'h5, 8'h41, 1'b0, 1'b0, 8'h41);
`ifdef FLOAT_MULT_RNE_EN
        run_one("round",  8'h3D, 8'h3B, 4'hA, 8'h41, 1'b0, 1'b0, 8'h41);
        run_one("carry",  8'h39, 8'h3E, 4'h2, 8'h40, 1'b0, 1'b0, 8'h40);
        run_one("rndovf", 8'h79, 8'h3E, 4'h6, 8'h00, 1'b1, 1'b0, 8'h7F);
`else
        run_one("round",  8'h3D, 8'h3B, 4'hA, 8'h40, 1'b0, 1'b0, 8'h40);
        run_one("carry",  8'h39, 8'h3E, 4'h2, 8'h3F, 1'b0, 1'b0, 8'h3F);
        run_one("rndovf", 8'h79, 8'h3E, 4'h6, 8'h7F, 1'b0, 1'b0, 8'h7F);
`endif
        run_one("tie",    8'h3A, 8'h3A, 4'h1, 8'h3C, 1'b0, 1'b0, 8'h3C);
        run_one("ovf",    8'h7F, 8'h7F, 4'h3, 8'h00, 1'b1, 1'b0, 8'h7F);
        run_one("ovfneg", 8'hFF, 8'h7F, 4'hC, 8'h00, 1'b1, 1'b0, 8'hFF);
        run_one("exp16",  8'h78, 8'h40, 4'h7, 8'h00, 1'b1, 1'b0, 8'h7F);
        run_one("expmax", 8'h78, 8'h38, 4'h8, 8'h78, 1'b0, 1'b0, 8'h78);
        run_one("exp0",   8'h01, 8'h38, 4'h9, 8'h01, 1'b0, 1'b0, 8'h01);
        run_one("unf",    8'h88, 8'h08, 4'hB, 8'h00, 1'b0, 1'b1, 8'h00);
        run_one("zero",   8'h80, 8'hBC, 4'hD, 8'h00, 1'b0, 1'b0, 8'h00);
        run_one("neg",    8'hB8, 8'h38, 4'hE, 8'hB8, 1'b0, 1'b0, 8'hB8);

        // Back-to-back stream with a five-cycle downstream stall in the middle.
        snd = 0; rcv = 0; stalls = 0;
        for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
            in_valid  = (snd < 8);
            in_a      = (snd < 8) ? sa[snd] : 8'h00;
            in_b      = (snd < 8) ? sb[snd] : 8'h00;
            in_tag    = 4'(snd + 1);
            out_ready = !(cyc >= 4 && cyc < 9);
            #1;
            if (out_valid) begin
                chk("stream", "p", 32'(out_p), 32'(sp[rcv]));
                chk("stream", "tag", 32'(out_tag), 32'(rcv + 1));
            end
            if (out_valid && !out_ready) begin
                stalls++;
                chk("stall", "in_ready", 32'(in_ready), 32'd0);
                chk("stall", "sat_in_ready", 32'(sat_in_ready), 32'd0);
            end
            if (out_valid && out_ready) rcv++;
            if (in_valid && in_ready) snd++;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream", "received", 32'(rcv), 32'd8);
        chk("stream", "sent", 32'(snd), 32'd8);
        chk("stream", "stall_cycles", 32'(stalls), 32'd5);
        step();
        chk("stream", "drained", 32'(out_valid), 32'd0);

        // Three operations in flight, then a synchronous reset.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 8'h3C; in_b = 8'h3C; in_tag = 4'(i + 4);
            step();
        end
        in_valid = 1'b0;
        chk("flight", "out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst", "out_valid", 32'(out_valid), 32'd0);
        chk("midrst", "out_p", 32'(out_p), 32'd0);
        chk("midrst", "out_tag", 32'(out_tag), 32'd0);
        chk("midrst", "flags", 32'({out_ovf, out_unf}), 32'd0);
        chk("midrst", "in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("midrst", "stale", 32'({out_valid, sat_out_valid}), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/float_mult_pipe.md
Name: float_mult_pipe

Overview:
- Parametrised, pipelined successor to the TPU's 8-bit float multiplier.
- Multiplies two sign/exponent/mantissa floats of configurable width in 3 pipeline stages with valid/ready handshake.
- Provides configurable overflow saturation, an underflow flag and a pass-through tag.
- Feeds the TPU MAC array; one result per cycle when not stalled.

Parameters:
- EXP_W, 4, exponent field width.
- MAN_W, 3, stored mantissa width; hidden 1 is implied.
- BIAS, 7, exponent bias. Must equal 2^(EXP_W-1)-1.
- SATURATE, 0, overflow result: 1 = signed max magnitude, 0 = +0.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts the operand pair this cycle.
- in_a  in  1+EXP_W+MAN_W  operand A as {sign, exp, man}.
- in_b  in  1+EXP_W+MAN_W  operand B.
- in_tag  in  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_p  out  1+EXP_W+MAN_W  product.
- out_tag  out  TAG_W  tag matching out_p.
- out_ovf  out  1  product overflowed the exponent range.
- out_unf  out  1  product underflowed and was flushed to zero.

Behaviour:
- Number format:
  - No subnormals, no inf/NaN.
  - An operand is zero iff its exp and man fields are all 0; the sign is ignored.
  - exp=0 with man!=0 is a normal value with biased exponent 0.
- Reset: out_valid=0, out_p=0, out_tag=0, out_ovf=0, out_unf=0, all stage valid bits 0. in_ready=1 in the first cycle after reset.
- Handshake:
  - Stall condition: stall = out_valid & ~out_ready.
  - in_ready = ~stall. On stall, every stage holds its contents.
  - A transfer happens on in_valid & in_ready. Bubbles are not collapsed.
  - out_* are stable while out_valid=1 and out_ready=0.
- Latency: exactly 3 cycles from accept to out_valid when there is no stall. Throughput is 1 per cycle.
- Stage 1:
  - sign = a.s ^ b.s.
  - Zero detect.
  - Exponent sum in EXP_W+2 bit signed arithmetic: ea+eb-BIAS.
  - Full (MAN_W+1)x(MAN_W+1) mantissa product, width 2*MAN_W+2.
- Stage 2, normalise:
  - If product MSB=1: exponent+1, mantissa = product[2*MAN_W:MAN_W+1], remainder = product[MAN_W:0].
  - Else: mantissa = product[2*MAN_W-1:MAN_W], remainder = product[MAN_W-1:0].
  - Default rounding is truncation.
- Stage 3, pack and classify:
  - Zero operand: out_p=0, ovf=0, unf=0.
  - Exponent > 2^EXP_W-1: out_ovf=1. out_p = {sign, all-ones} if SATURATE, else 0.
  - Exponent < 0: out_unf=1, out_p=0.
  - Exponent == 0 is a valid result.
  - Any zero result is +0 (sign bit 0).
- Simultaneous accept and output on the same cycle are both legal.
- Reset mid-operation discards all in-flight results; no out_valid follows from pre-reset inputs.

Optional Feature:
- Macro: FLOAT_MULT_RNE_EN.
- Defined: round-to-nearest-even using the remainder.
  - Increment the mantissa if remainder > half, or if remainder == half and mantissa LSB=1.
  - A mantissa carry-out renormalises: mantissa=0, exponent+1. Overflow is rechecked after rounding.
  - Latency is unchanged at 3.
- Undefined: truncation only; the remainder logic is not synthesised.

Decomposition:
- Shared package tpu_float_pkg holds:
  - default EXP_W/MAN_W/BIAS constants;
  - function fp_is_zero;
  - localparams for the max exponent and field positions.
- One sub-module, float_norm_round: combinational normalise plus optional RNE, instantiated in stage 2/3.
- Pipeline registers and handshake stay in float_mult_pipe.

Test Plan:
- Defaults: 0x3C*0x3C (1.5*1.5), out_ready=1 -> after 3 cycles out_p=0x41, ovf=0, unf=0; tag is echoed.
- 0x3D*0x3B (1.625*1.375) -> 0x40 with truncation; 0x41 with FLOAT_MULT_RNE_EN.
- 0x7F*0x7F -> out_ovf=1, out_p=0x00 (SATURATE=0) or 0x7F (SATURATE=1). 0xFF*0x7F with SATURATE=1 -> 0xFF.
- Underflow, zero and sign cases:
  - 0x08*0x08 -> out_unf=1, out_p=0x00.
  - 0x80*0x3C -> 0x00, no flags.
  - 0xB8*0x38 -> 0xB8.
- Stream 8 back-to-back pairs and hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the stall, no loss or duplication, results and tags in order.
- Assert rst while 3 operations are in flight -> next cycle all outputs are 0; no stale out_valid afterwards.
